// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared constants and types for the instruction-memory loader.
//   - LDR_HEADER / LDR_DEPTH / LDR_ADRS_W / LDR_TIMEOUT: default frame format
//   - ldr_state_e: loader FSM encoding (2 bits)
//   - ldr_sum8: modulo-256 running checksum step
package program_loader_pkg;

   localparam logic [7:0] LDR_HEADER  = 8'hA5;
   localparam int         LDR_DEPTH   = 16;
   localparam int         LDR_ADRS_W  = 4;
   localparam int         LDR_TIMEOUT = 50000;
   localparam int         LDR_TIMER_W = 16;

   typedef enum logic [1:0] {
      LDR_IDLE  = 2'd0,
      LDR_LOAD  = 2'd1,
      LDR_WRITE = 2'd2,
      LDR_CHECK = 2'd3
   } ldr_state_e;

   function automatic logic [7:0] ldr_sum8(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction

endpackage

// File: rtl/program_loader_timer.sv
// load_timer
//   Idle-gap watchdog. Counts enabled cycles since the last clear and flags
//   the cycle on which the count would reach TIMEOUT.
//   - clk, reset : clock, async active-high reset
//   - clear      : zero the count (wins over enable)
//   - enable     : count this cycle
//   - expired    : this edge is the TIMEOUT-th consecutive enabled cycle
module load_timer #(
   parameter int TIMEOUT = 50000,
   parameter int W       = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Fires on the edge that completes TIMEOUT idle cycles; an accept on the
   // same edge clears instead, so a byte arriving just in time still counts.
   assign expired = enable & ~clear & (cnt_q == LAST);

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Writer side of the CPU instruction RAM. Accepts a framed byte stream
//   (HEADER, DEPTH payload bytes, checksum), writes the payload to RAM
//   addresses 0..DEPTH-1 and holds the CPU until a frame checks out.
//   - clk, reset       : clock, async active-high reset
//   - in_data/valid    : stream byte in, accepted when in_valid && in_ready
//   - in_ready         : loader can take a byte (low in WRITE and in reset)
//   - mem_we/adrs/data : RAM write port, one-cycle strobe
//   - cpu_hold         : keep CPU in reset while loading / after a bad frame
//   - busy             : frame in progress
//   - load_done        : sticky, last frame good
//   - load_err         : sticky, last frame bad (checksum or timeout)
module program_loader
   import program_loader_pkg::*;
#(
   parameter logic [7:0] HEADER  = LDR_HEADER,
   parameter int         DEPTH   = LDR_DEPTH,
   parameter int         ADRS_W  = LDR_ADRS_W,
   parameter int         TIMEOUT = LDR_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADRS_W-1:0] mem_adrs,
   output logic [7:0]        mem_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              load_done,
   output logic              load_err
);

   localparam logic [ADRS_W-1:0] LAST_ADRS = ADRS_W'(DEPTH - 1);

   ldr_state_e        state_q, state_d;
   logic [ADRS_W-1:0] count_q, count_d;
   logic [7:0]        sum_q, sum_d;
   logic [ADRS_W-1:0] mem_adrs_q, mem_adrs_d;
   logic [7:0]        mem_data_q, mem_data_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              busy_q, busy_d;
   logic              load_done_q, load_done_d;
   logic              load_err_q, load_err_d;
   logic              timer_clr, timer_en, timer_expired;

   load_timer #(
      .TIMEOUT (TIMEOUT),
      .W       (LDR_TIMER_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clr),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   // in_ready is gated by reset so it reads 0 while reset is held, even
   // though the state register already sits in IDLE.
   assign in_ready = ~reset & (state_q != LDR_WRITE);
   assign mem_we   = (state_q == LDR_WRITE);

   // Inside each accepting state in_ready is known high, so in_valid alone
   // marks an accept; this keeps in_ready out of the next-state logic.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      sum_d       = sum_q;
      mem_adrs_d  = mem_adrs_q;
      mem_data_d  = mem_data_q;
      cpu_hold_d  = cpu_hold_q;
      busy_d      = busy_q;
      load_done_d = load_done_q;
      load_err_d  = load_err_q;
      timer_clr   = 1'b1;
      timer_en    = 1'b0;

      unique case (state_q)
         LDR_IDLE: begin
            if (in_valid && in_data == HEADER) begin
               state_d     = LDR_LOAD;
               cpu_hold_d  = 1'b1;
               busy_d      = 1'b1;
               load_done_d = 1'b0;
               load_err_d  = 1'b0;
               count_d     = '0;
               sum_d       = '0;
            end
         end

         LDR_LOAD: begin
            timer_en  = 1'b1;
            timer_clr = in_valid;
            if (in_valid) begin
               // A header byte here is just payload: no resync mid-frame.
               state_d    = LDR_WRITE;
               mem_adrs_d = count_q;
               mem_data_d = in_data;
               sum_d      = ldr_sum8(sum_q, in_data);
            end else if (timer_expired) begin
               state_d    = LDR_IDLE;
               busy_d     = 1'b0;
               load_err_d = 1'b1;
            end
         end

         LDR_WRITE: begin
            count_d = count_q + 1'b1;
            state_d = (mem_adrs_q == LAST_ADRS) ? LDR_CHECK : LDR_LOAD;
         end

         LDR_CHECK: begin
            timer_en  = 1'b1;
            timer_clr = in_valid;
            if (in_valid) begin
               state_d = LDR_IDLE;
               busy_d  = 1'b0;
               if (ldr_sum8(sum_q, in_data) == 8'h00) begin
                  load_done_d = 1'b1;
                  cpu_hold_d  = 1'b0;
               end else begin
                  load_err_d  = 1'b1;
               end
            end else if (timer_expired) begin
               state_d    = LDR_IDLE;
               busy_d     = 1'b0;
               load_err_d = 1'b1;
            end
         end

         default: state_d = LDR_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= LDR_IDLE;
         count_q     <= '0;
         sum_q       <= '0;
         mem_adrs_q  <= '0;
         mem_data_q  <= '0;
         cpu_hold_q  <= 1'b0;
         busy_q      <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         sum_q       <= sum_d;
         mem_adrs_q  <= mem_adrs_d;
         mem_data_q  <= mem_data_d;
         cpu_hold_q  <= cpu_hold_d;
         busy_q      <= busy_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
      end
   end

   assign mem_adrs  = mem_adrs_q;
   assign mem_data  = mem_data_q;
   assign cpu_hold  = cpu_hold_q;
   assign busy      = busy_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
   import program_loader_pkg::*;

   localparam int WAIT_MAX = 50;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       mem_we;
   logic [3:0] mem_adrs;
   logic [7:0] mem_data;
   logic       cpu_hold;
   logic       busy;
   logic       load_done;
   logic       load_err;

   int tests = 0;
   int fails = 0;

   logic [11:0] exp_q [$];
   logic [7:0]  pl [16];

   program_loader #(
      .HEADER  (8'hA5),
      .DEPTH   (16),
      .ADRS_W  (4),
      .TIMEOUT (20)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_adrs  (mem_adrs),
      .mem_data  (mem_data),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         tests++;
         assert (exp_q.size() > 0) else begin
            fails++;
            $error("FAIL we_spurious observed=adrs %0h data %0h expected=no write", mem_adrs, mem_data);
         end
         if (exp_q.size() > 0)
            check("we_adrs_data", {20'h0, mem_adrs, mem_data}, {20'h0, exp_q.pop_front()});
      end
   end

   // Drive one byte, wait for the accept edge, then look half a cycle later.
   task automatic send(input logic [7:0] b, input bit we_exp, input bit hold_valid);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < WAIT_MAX) begin
         @(negedge clk);
         n++;
      end
      if (n >= WAIT_MAX) check("ready_wait_expired", 32'(n), 32'(WAIT_MAX - 1));
      @(posedge clk);
      @(negedge clk);
      check("we_after_accept", {31'h0, mem_we}, {31'h0, we_exp});
      check("in_ready_toggle", {31'h0, in_ready}, {31'h0, ~we_exp});
      if (!hold_valid) in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] cks, input bit hv);
      send(8'hA5, 1'b0, hv);
      check("hdr_cpu_hold", {31'h0, cpu_hold}, 32'h1);
      check("hdr_busy", {31'h0, busy}, 32'h1);
      check("hdr_clears_err", {31'h0, load_err}, 32'h0);
      check("hdr_clears_done", {31'h0, load_done}, 32'h0);
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({4'(i), pl[i]});
         send(pl[i], 1'b1, hv);
      end
      send(cks, 1'b0, hv);
      in_valid = 1'b0;
      check("frame_writes_drained", 32'(exp_q.size()), 32'h0);
      check("frame_busy_clear", {31'h0, busy}, 32'h0);
   endtask

   function automatic logic [7:0] calc_cks();
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 16; i++) s = s + pl[i];
      return 8'h00 - s;
   endfunction

   task automatic expect_status(input string tag, input bit done, input bit err, input bit hold);
      check({tag, "_done"}, {31'h0, load_done}, {31'h0, done});
      check({tag, "_err"},  {31'h0, load_err},  {31'h0, err});
      check({tag, "_hold"}, {31'h0, cpu_hold},  {31'h0, hold});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=still running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #3;
      check("rst_outputs", {20'h0, in_ready, mem_we, cpu_hold, busy, load_done, load_err, mem_adrs, mem_data}, 32'h0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {31'h0, in_ready}, 32'h1);
      check("post_rst_hold", {31'h0, cpu_hold}, 32'h0);

      // Good frame, checksum constant worked out by hand.
      for (int i = 0; i < 16; i++) pl[i] = 8'(8'h10 + i);
      send_frame(8'h88, 1'b0);
      expect_status("good", 1'b1, 1'b0, 1'b0);

      // Bad checksum, then a good frame clears the error and releases CPU.
      send_frame(8'h00, 1'b0);
      expect_status("badcks", 1'b0, 1'b1, 1'b1);
      send_frame(8'h88, 1'b0);
      expect_status("recover", 1'b1, 1'b0, 1'b0);

      // Garbage before header is dropped; header value as payload is data.
      send(8'h00, 1'b0, 1'b0);
      send(8'hFF, 1'b0, 1'b0);
      send(8'h3C, 1'b0, 1'b0);
      check("garbage_busy", {31'h0, busy}, 32'h0);
      for (int i = 0; i < 16; i++) pl[i] = 8'(8'h30 + 3 * i);
      pl[3] = 8'hA5;
      send_frame(calc_cks(), 1'b0);
      expect_status("hdr_payload", 1'b1, 1'b0, 1'b0);

      // Valid held high the whole frame: 1 byte per 2 cycles, no loss/dup.
      for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
      send_frame(calc_cks(), 1'b1);
      expect_status("stream", 1'b1, 1'b0, 1'b0);

      // Timeout after header + 5 bytes.
      for (int i = 0; i < 16; i++) pl[i] = 8'(8'hC0 + i);
      send(8'hA5, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back({4'(i), pl[i]});
         send(pl[i], 1'b1, 1'b0);
      end
      repeat (10) @(negedge clk);
      check("to_still_busy", {31'h0, busy}, 32'h1);
      check("to_no_err_yet", {31'h0, load_err}, 32'h0);
      repeat (15) @(negedge clk);
      check("to_busy", {31'h0, busy}, 32'h0);
      expect_status("timeout", 1'b0, 1'b1, 1'b1);
      send(8'h11, 1'b0, 1'b0);
      send(8'h22, 1'b0, 1'b0);
      check("to_idle_no_writes", 32'(exp_q.size()), 32'h0);
      check("to_idle_busy", {31'h0, busy}, 32'h0);

      // Reset mid-frame, between clock edges.
      send(8'hA5, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back({4'(i), pl[i]});
         send(pl[i], 1'b1, 1'b0);
      end
      #2 reset = 1'b1;
      #1;
      check("midrst_outputs", {20'h0, in_ready, mem_we, cpu_hold, busy, load_done, load_err, mem_adrs, mem_data}, 32'h0);
      repeat (3) @(negedge clk);
      check("midrst_no_we", {31'h0, mem_we}, 32'h0);
      #2 reset = 1'b0;
      @(negedge clk);
      check("midrst_drained", 32'(exp_q.size()), 32'h0);
      for (int i = 0; i < 16; i++) pl[i] = 8'(8'hF0 - i);
      send_frame(calc_cks(), 1'b0);
      expect_status("after_rst", 1'b1, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the CPU's instruction memory.
- Receives a framed byte stream from a host-side byte source over a valid/ready handshake.
- Writes 16 instruction bytes into the 16x8 instruction RAM through a single write port, and holds the CPU while loading.
- Validates the frame with a checksum and a timeout, then releases the CPU to run the new program from address 0.

Parameters:
- HEADER, 8'hA5, frame start byte.
- DEPTH, 16, number of payload bytes (instruction words) per frame.
- ADRS_W, 4, memory address width; DEPTH == 2**ADRS_W.
- TIMEOUT, 50000, maximum idle clk cycles between bytes inside a frame.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  instruction RAM write strobe, one-cycle pulse
- mem_adrs  out  ADRS_W  write address
- mem_data  out  8  write data
- cpu_hold  out  1  hold CPU (PC and registers) in reset
- busy  out  1  frame in progress
- load_done  out  1  sticky: last frame loaded and checksum passed
- load_err  out  1  sticky: last frame failed (checksum or timeout)

Behaviour:
- Reset is asynchronous and active-high. All outputs reset to 0 and the state resets to IDLE.
- Reset values: cpu_hold=0 (CPU runs resident program), mem_we=0, mem_adrs=0, mem_data=0, in_ready=0, load_done=0, load_err=0, sum=0, count=0.
- A byte is accepted when in_valid && in_ready at a rising clk edge.
- States: IDLE, LOAD, WRITE, CHECK.
- IDLE:
  - in_ready=1.
  - An accepted byte equal to HEADER moves to LOAD. On that edge: cpu_hold<=1, busy<=1, load_done<=0, load_err<=0, count<=0, sum<=0, timer cleared.
  - Other accepted bytes are discarded silently.
- LOAD:
  - in_ready=1.
  - An accepted byte moves to WRITE, registering mem_adrs<=count, mem_data<=in_data, sum<=sum+in_data (mod 256).
  - HEADER inside LOAD is plain data; there is no resync.
- WRITE:
  - Lasts one cycle. mem_we=1 and in_ready=0.
  - count increments. If the written address was DEPTH-1, go to CHECK; otherwise return to LOAD.
  - Latency: byte accept edge to mem_we high is exactly 1 cycle. Sustained throughput is 1 byte per 2 cycles.
- CHECK:
  - in_ready=1. The next accepted byte is the checksum.
  - If (sum + byte) mod 256 == 0: load_done<=1, cpu_hold<=0.
  - Otherwise: load_err<=1, cpu_hold stays 1.
  - In both cases busy<=0 and the state returns to IDLE.
- Timeout:
  - A 16-bit timer counts cycles spent in LOAD or CHECK without an accepted byte; it clears on every accept.
  - When the timer reaches TIMEOUT: load_err<=1, busy<=0, state<=IDLE, cpu_hold stays 1.
  - The timer is frozen and cleared in IDLE and WRITE.
- cpu_hold release:
  - After any error, cpu_hold falls only on a later successful frame or on reset.
  - cpu_hold falls on the same edge load_done rises. The CPU's first fetch after release is address 0.
- mem_we is never asserted outside WRITE. Exactly DEPTH pulses occur per complete frame, at addresses 0..DEPTH-1 in order.
- Reset mid-frame: aborts immediately. Partial writes remain in RAM. cpu_hold=0, so the CPU runs possibly mixed contents; the host must resend.
- load_done and load_err are never both 1.

Decomposition:
- defines.v gains:
  - `LDR_HEADER (8'hA5)
  - state encodings `LDR_IDLE, `LDR_LOAD, `LDR_WRITE, `LDR_CHECK (2 bits)
  - `LDR_TIMEOUT
- One sub-module: load_timer (clear, enable, TIMEOUT parameter, expired output), reused for the idle-gap timeout.
- The instruction memory becomes a dual-port RAM (write port from this block, read port to the CPU). That change is outside this block.

Test Plan:
- Good frame: A5, bytes 0x10..0x1F, checksum 0x88 (sum 0x178 → 0x78; 0x100-0x78) → 16 mem_we pulses, adrs 0..15 with data 0x10..0x1F. load_done=1, cpu_hold rises at header accept and falls on checksum accept, load_err=0.
- Bad checksum: same frame with checksum 0x00 → 16 writes, load_err=1, load_done=0, cpu_hold stays 1. A following good frame clears load_err and drops cpu_hold.
- Garbage before header: 0x00, 0xFF, 0x3C, then good frame → no writes from garbage bytes, frame loads normally. A5 as payload byte 3 is written as data to adrs 3.
- Handshake: in_valid held high continuously → in_ready toggles 1/0, one byte per 2 cycles, no byte lost or duplicated, mem_we exactly 1 cycle after each accept.
- Timeout: TIMEOUT=20, header + 5 bytes, then in_valid=0 for 20 cycles → load_err=1, busy=0, state IDLE, cpu_hold=1. Bytes without a header afterwards produce no writes.
- Reset mid-frame: assert reset after 7 payload bytes, asynchronously between edges → all outputs 0 immediately (cpu_hold=0, in_ready=0), no further mem_we. A new frame after deassert loads correctly.
